multicycle_control: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and write-back. Each cycle it drives the datapath mux selects and write enables, including the immediate extender mode select: sign-extend or zero-extend. It also stalls on a memory-ready handshake, so the shared instruction/data memory can take extra cycles.

---
 rtl/multicycle_control.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multi-cycle MIPS datapath
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [1:0] pc_source,
   output logic       ext_sel,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXEC   = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_I_EXEC   = 4'd10,
      S_I_WB     = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;

   state_t     state_q;
   state_t     state_d;
   logic [5:0] op_q;

   assign state = state_q;

   // State register; the opcode is captured in DECODE so later states see a stable copy
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         op_q    <= 6'd0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            op_q <= opcode;
         end
      end
   end

   // Next-state and datapath controls; enables are squashed while reset is held
   always_comb begin
      state_d       = S_FETCH;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 3'b000;
      pc_source     = 2'b00;
      ext_sel       = 1'b0;
      illegal_op    = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else begin
               state_d  = S_FETCH;
            end
         end
         S_DECODE: begin
            // Speculatively compute the branch target into ALUOut
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
               OP_R:                               state_d = S_R_EXEC;
               OP_BEQ:                             state_d = S_BRANCH;
               OP_J:                               state_d = S_JUMP;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  state_d = S_I_EXEC;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (op_q == OP_LW) begin
               state_d = S_MEM_RD;
            end else if (op_q == OP_SW) begin
               state_d = S_MEM_WR;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            state_d  = mem_ready ? S_MEM_WB : S_MEM_RD;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            state_d   = mem_ready ? S_FETCH : S_MEM_WR;
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 3'b010;
            state_d   = S_R_WB;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 3'b001;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         S_I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_I_WB;
            case (op_q)
               OP_SLTI: alu_op = 3'b101;
               OP_ANDI: begin
                  alu_op  = 3'b011;
                  ext_sel = 1'b1;
               end
               OP_ORI: begin
                  alu_op  = 3'b100;
                  ext_sel = 1'b1;
               end
               default: alu_op = 3'b000;
            endcase
         end
         S_I_WB: begin
            reg_write = 1'b1;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      if (reset) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         reg_write     = 1'b0;
         illegal_op    = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed vector bench for multicycle_control
module tb_multicycle_control;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ext_sel, illegal_op;
   logic [1:0] alu_src_b, pc_source;
   logic [2:0] alu_op;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .ext_sel(ext_sel), .illegal_op(illegal_op),
      .state(state)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
   localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;
   localparam logic [5:0] SLTI = 6'b001010, ANDI = 6'b001100, ORI = 6'b001101;

   // Field order: pcw pcwc iord mrd mwr irw m2r rdst rw asa | asb | aop | psrc | ext | ill
   localparam logic [18:0] C_FETCH_RST  = 19'b0000000000_01_000_00_0_0;
   localparam logic [18:0] C_FETCH_RDY  = 19'b1001010000_01_000_00_0_0;
   localparam logic [18:0] C_FETCH_WAIT = 19'b0001000000_01_000_00_0_0;
   localparam logic [18:0] C_DEC        = 19'b0000000000_11_000_00_0_0;
   localparam logic [18:0] C_DEC_ILL    = 19'b0000000000_11_000_00_0_1;
   localparam logic [18:0] C_MEMADDR    = 19'b0000000001_10_000_00_0_0;
   localparam logic [18:0] C_MEMRD      = 19'b0011000000_00_000_00_0_0;
   localparam logic [18:0] C_MEMWB      = 19'b0000001010_00_000_00_0_0;
   localparam logic [18:0] C_MEMWR      = 19'b0010100000_00_000_00_0_0;
   localparam logic [18:0] C_REXEC      = 19'b0000000001_00_010_00_0_0;
   localparam logic [18:0] C_RWB        = 19'b0000000110_00_000_00_0_0;
   localparam logic [18:0] C_BRANCH     = 19'b0100000001_00_001_01_0_0;
   localparam logic [18:0] C_JUMP       = 19'b1000000000_00_000_10_0_0;
   localparam logic [18:0] C_IADDI      = 19'b0000000001_10_000_00_0_0;
   localparam logic [18:0] C_ISLTI      = 19'b0000000001_10_101_00_0_0;
   localparam logic [18:0] C_IANDI      = 19'b0000000001_10_011_00_1_0;
   localparam logic [18:0] C_IORI       = 19'b0000000001_10_100_00_1_0;
   localparam logic [18:0] C_IWB        = 19'b0000000010_00_000_00_0_0;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic        rdy;
      logic [3:0]  exp_state;
      logic [18:0] exp_ctl;
   } vec_t;

   vec_t vq[$];

   logic [18:0] act_ctl;
   assign act_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_source, ext_sel, illegal_op};

   task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                      input logic [3:0] st, input logic [18:0] ctl);
      vec_t v;
      v.rst = rst; v.op = op; v.rdy = rdy; v.exp_state = st; v.exp_ctl = ctl;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Count edges from FETCH until FETCH is seen again, with mem_ready tied high
   task automatic run_latency(input logic [5:0] op, input int exp, input string name);
      int n;
      @(negedge clk);
      opcode = op;
      mem_ready = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (state != 4'd0 && n < 20);
      check(name, n, exp);
   endtask

   initial begin
      reset = 1'b1;
      opcode = 6'd0;
      mem_ready = 1'b1;

      // reset held 3 cycles
      add(1, 0, 1, 0, C_FETCH_RST);
      add(1, 0, 1, 0, C_FETCH_RST);
      add(1, 0, 1, 0, C_FETCH_RST);
      add(0, 0, 1, 0, C_FETCH_RDY);
      // lw, no stalls
      add(0, LW, 1, 1, C_DEC);
      add(0, 0, 1, 2, C_MEMADDR);
      add(0, 0, 1, 3, C_MEMRD);
      add(0, 0, 1, 4, C_MEMWB);
      // fetch stall
      add(0, 0, 0, 0, C_FETCH_WAIT);
      add(0, 0, 0, 0, C_FETCH_WAIT);
      add(0, 0, 1, 0, C_FETCH_RDY);
      // lw with 3 stall cycles in MEM_RD
      add(0, LW, 1, 1, C_DEC);
      add(0, 0, 1, 2, C_MEMADDR);
      add(0, 0, 0, 3, C_MEMRD);
      add(0, 0, 0, 3, C_MEMRD);
      add(0, 0, 0, 3, C_MEMRD);
      add(0, 0, 1, 3, C_MEMRD);
      add(0, 0, 1, 4, C_MEMWB);
      // sw; live opcode changed after DECODE must not matter
      add(0, 0, 1, 0, C_FETCH_RDY);
      add(0, SW, 1, 1, C_DEC);
      add(0, LW, 1, 2, C_MEMADDR);
      add(0, 0, 0, 5, C_MEMWR);
      add(0, 0, 1, 5, C_MEMWR);
      // R-type; mem_ready low outside memory states is ignored
      add(0, 0, 1, 0, C_FETCH_RDY);
      add(0, R, 0, 1, C_DEC);
      add(0, 0, 0, 6, C_REXEC);
      add(0, 0, 0, 7, C_RWB);
      // beq
      add(0, 0, 1, 0, C_FETCH_RDY);
      add(0, BEQ, 1, 1, C_DEC);
      add(0, 0, 1, 8, C_BRANCH);
      // j
      add(0, 0, 1, 0, C_FETCH_RDY);
      add(0, J, 1, 1, C_DEC);
      add(0, 0, 1, 9, C_JUMP);
      // ori with live opcode swapped to addi in I_EXEC
      add(0, 0, 1, 0, C_FETCH_RDY);
      add(0, ORI, 1, 1, C_DEC);
      add(0, ADDI, 1, 10, C_IORI);
      add(0, 0, 1, 11, C_IWB);
      // addi with live opcode swapped to ori
      add(0, 0, 1, 0, C_FETCH_RDY);
      add(0, ADDI, 1, 1, C_DEC);
      add(0, ORI, 1, 10, C_IADDI);
      add(0, 0, 1, 11, C_IWB);
      // slti
      add(0, 0, 1, 0, C_FETCH_RDY);
      add(0, SLTI, 1, 1, C_DEC);
      add(0, 0, 1, 10, C_ISLTI);
      add(0, 0, 1, 11, C_IWB);
      // andi
      add(0, 0, 1, 0, C_FETCH_RDY);
      add(0, ANDI, 1, 1, C_DEC);
      add(0, 0, 1, 10, C_IANDI);
      add(0, 0, 1, 11, C_IWB);
      // illegal opcode
      add(0, 0, 1, 0, C_FETCH_RDY);
      add(0, 6'b111111, 1, 1, C_DEC_ILL);
      add(0, 0, 1, 0, C_FETCH_RDY);
      add(0, J, 1, 1, C_DEC);
      add(0, 0, 1, 9, C_JUMP);

      foreach (vq[i]) begin
         @(negedge clk);
         reset = vq[i].rst;
         opcode = vq[i].op;
         mem_ready = vq[i].rdy;
         #1;
         check($sformatf("vec%0d state", i), 32'(state), 32'(vq[i].exp_state));
         check($sformatf("vec%0d ctl", i), 32'(act_ctl), 32'(vq[i].exp_ctl));
         check($sformatf("vec%0d one_mem_req", i), 32'(mem_read & mem_write), 32'd0);
      end

      // latencies with mem_ready tied high
      run_latency(LW,   5, "lat_lw");
      run_latency(SW,   4, "lat_sw");
      run_latency(R,    4, "lat_r");
      run_latency(BEQ,  3, "lat_beq");
      run_latency(J,    3, "lat_j");
      run_latency(ORI,  4, "lat_ori");

      // reset asserted mid-store abandons the write
      @(negedge clk);
      opcode = SW;
      mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("mid_sw state", 32'(state), 32'd5);
      check("mid_sw mem_write", 32'(mem_write), 32'd1);
      reset = 1'b1;
      #1;
      check("rst_sw mem_write", 32'(mem_write), 32'd0);
      @(negedge clk);
      check("rst_sw state", 32'(state), 32'd0);
      check("rst_sw enables", 32'({mem_read, ir_write, pc_write, mem_write}), 32'd0);
      reset = 1'b0;
      mem_ready = 1'b1;
      #1;
      check("post_rst ir_write", 32'(ir_write), 32'd1);
      check("post_rst pc_write", 32'(pc_write), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
